// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: sequencer states, data-memory map defaults and byte-lane helper.
package mult_seq_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, READ, DONE} seq_state_t;
    localparam int OP_BYTES = 2;
    localparam int RES_BYTES = 4;
    localparam logic [7:0] DEF_OPA_ADDR = 8'd0;
    localparam logic [7:0] DEF_OPB_ADDR = 8'd2;
    localparam logic [7:0] DEF_RES_ADDR = 8'd4;
    function automatic logic [7:0] byte_addr(input logic [7:0] base, input logic [1:0] off);
        return base + {6'd0, off};
    endfunction
endpackage

// File: rtl/mult_job_sequencer_if.sv
// mult_job_sequencer_if: operand/result handshakes plus core and data-memory strobes.
interface mult_job_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_op_a;
    logic [15:0] in_op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;
    logic        busy;
    logic        core_start;
    logic        core_ack;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic [7:0]  dm_rdata;
    modport master (
        input  in_valid, in_op_a, in_op_b, out_ready, core_ack, dm_rdata,
        output in_ready, out_valid, out_result, out_err, busy, core_start, dm_we, dm_addr, dm_wdata
    );
    modport slave (
        output in_valid, in_op_a, in_op_b, out_ready, core_ack, dm_rdata,
        input  in_ready, out_valid, out_result, out_err, busy, core_start, dm_we, dm_addr, dm_wdata
    );
endinterface

// File: rtl/cycle_watchdog.sv
// cycle_watchdog: counts enabled cycles since the last clear; expired_o marks the LIMIT-th one.
module cycle_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign expired_o = cnt_q == W'(LIMIT - 1);
    always_comb cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: loads an operand pair into core data memory, starts the core,
// waits for Ack (with watchdog) and returns the 32-bit result read back from memory.
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter logic [7:0] OPA_ADDR    = DEF_OPA_ADDR,
    parameter logic [7:0] OPB_ADDR    = DEF_OPB_ADDR,
    parameter logic [7:0] RES_ADDR    = DEF_RES_ADDR,
    parameter int         START_CYC   = 1,
    parameter int         TIMEOUT_CYC = 4096
) (
    input logic clk,
    input logic rst_n,
    mult_job_sequencer_if.master bus_io
);
    seq_state_t  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] ops_q, ops_d;
    logic [31:0] res_q, res_d;
    logic        err_q, err_d;
    logic        start_done, wait_expired;

    cycle_watchdog #(.LIMIT(START_CYC)) u_start_hold (
        .clk(clk), .rst_n(rst_n), .clr_i(state_q != LAUNCH), .en_i(state_q == LAUNCH), .expired_o(start_done)
    );
    cycle_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wait_dog (
        .clk(clk), .rst_n(rst_n), .clr_i(state_q != WAIT), .en_i(state_q == WAIT), .expired_o(wait_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d = '0;
        ops_d = ops_q;
        res_d = res_q;
        err_d = err_q;
        bus_io.in_ready = state_q == IDLE;
        bus_io.busy = state_q != IDLE;
        bus_io.core_start = state_q == LAUNCH;
        bus_io.dm_we = state_q == LOAD;
        bus_io.out_valid = state_q == DONE;
        bus_io.out_result = (state_q == DONE) ? res_q : '0;
        bus_io.out_err = (state_q == DONE) && err_q;
        // Operand bytes go out MSB first: A hi, A lo, B hi, B lo.
        bus_io.dm_addr = (state_q == LOAD) ? byte_addr(idx_q[1] ? OPB_ADDR : OPA_ADDR, {1'b0, idx_q[0]}) :
                         (state_q == READ) ? byte_addr(RES_ADDR, idx_q) : '0;
        bus_io.dm_wdata = (state_q == LOAD) ? ops_q[{~idx_q, 3'b111} -: 8] : '0;
        case (state_q)
            IDLE: if (bus_io.in_valid) begin
                state_d = LOAD;
                ops_d = {bus_io.in_op_a, bus_io.in_op_b};
                res_d = '0;
                err_d = 1'b0;
            end
            LOAD: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'(2 * OP_BYTES - 1)) state_d = LAUNCH;
            end
            LAUNCH: if (start_done) state_d = WAIT;
            WAIT: if (bus_io.core_ack) state_d = READ;
                  else if (wait_expired) begin
                      state_d = DONE;
                      err_d = 1'b1;
                      res_d = '0;
                  end
            READ: begin
                idx_d = idx_q + 2'd1;
                res_d = {res_q[23:0], bus_io.dm_rdata};
                if (idx_q == 2'(RES_BYTES - 1)) state_d = DONE;
            end
            DONE: if (bus_io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            ops_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            ops_q <= ops_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end
endmodule
